drive_ndig_7seg: RTL

DRIVE_NDIG_7SEG -- requirements
Module: drive_ndig_7seg

---
 rtl/drive_7seg_pkg.sv | 32 +++
 rtl/seg7_font.sv | 16 +
 rtl/drive_ndig_7seg.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/drive_7seg_pkg.sv
// Shared constants for the multiplexed 7-segment driver: segment bit positions,
// hex font table and a constant-foldable ceil(log2) helper.
package drive_7seg_pkg;

    localparam int SEG_DP = 7;
    localparam int SEG_A  = 6;
    localparam int SEG_B  = 5;
    localparam int SEG_C  = 4;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 2;
    localparam int SEG_F  = 1;
    localparam int SEG_G  = 0;

    // Active-high {a,b,c,d,e,f,g}, indexed by the hex value of the nibble.
    localparam logic [6:0] FONT_TABLE [16] = '{
        7'h7E, 7'h30, 7'h6D, 7'h79,
        7'h33, 7'h5B, 7'h5F, 7'h70,
        7'h7F, 7'h7B, 7'h77, 7'h1F,
        7'h4E, 7'h3D, 7'h4F, 7'h47
    };

    // Never returns less than 1 so that counters always have a real bit.
    function automatic int clog2(input int value);
        int bits;
        bits = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            bits++;
        end
        return (bits < 1) ? 1 : bits;
    endfunction

endpackage

// File: rtl/seg7_font.sv
// Hex nibble plus decimal point to active-high {dp,a,b,c,d,e,f,g}.
module seg7_font
    import drive_7seg_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       dp,
    output logic [7:0] segments
);

    always_comb begin
        segments                = '0;
        segments[SEG_DP]        = dp;
        segments[SEG_A:SEG_G]   = FONT_TABLE[nibble];
    end

endmodule

// File: rtl/drive_ndig_7seg.sv
// Time-multiplexed N-digit 7-segment driver with double-buffered display data,
// PWM-style brightness per slot and optional leading-zero suppression.
module drive_ndig_7seg
    import drive_7seg_pkg::*;
#(
    parameter int NDIG        = 8,
    parameter int DSTEP       = 100,
    parameter int BRIGHT_W    = 4,
    parameter bit SEL_ACT_LOW = 1'b0,
    parameter bit SEG_ACT_LOW = 1'b1
) (
    input  logic                  xClk,
    input  logic                  xRst_n,
    input  logic [4*NDIG-1:0]     xDInput,
    input  logic [NDIG-1:0]       xDp,
    input  logic [NDIG-1:0]       xBlank,
    input  logic                  xLzs,
    input  logic                  xLoad,
    input  logic [BRIGHT_W-1:0]   xBright,
    output logic [NDIG-1:0]       xSelect,
    output logic [7:0]            xSegment,
    output logic                  xFrame
);

    localparam int DW = clog2(DSTEP);
    localparam int SW = clog2(NDIG);

    localparam logic [DW-1:0]   DWELL_LAST = DW'(DSTEP - 1);
    localparam logic [SW-1:0]   SLOT_LAST  = SW'(NDIG - 1);
    localparam logic [NDIG-1:0] SEL_OFF    = SEL_ACT_LOW ? {NDIG{1'b1}} : {NDIG{1'b0}};
    localparam logic [7:0]      SEG_OFF    = SEG_ACT_LOW ? 8'hFF : 8'h00;

    logic                run;
    logic [DW-1:0]       dwell;
    logic [SW-1:0]       slot;
    logic                frame_start;

    logic                pend;
    logic [4*NDIG-1:0]   pend_data;
    logic [NDIG-1:0]     pend_dp;
    logic [NDIG-1:0]     pend_blank;
    logic                pend_lzs;

    logic [4*NDIG-1:0]   shd_data;
    logic [NDIG-1:0]     shd_dp;
    logic [NDIG-1:0]     shd_blank;
    logic                shd_lzs;

    logic [4*NDIG-1:0]   nxt_data;
    logic [NDIG-1:0]     nxt_dp;
    logic [NDIG-1:0]     nxt_blank;
    logic                nxt_lzs;

    logic [NDIG-1:0]     supp;
    logic                zero_run;
    logic [SW-1:0]       dig_idx;
    logic [3:0]          cur_nib;
    logic                cur_dp;
    logic                cur_dark;
    logic [31:0]         t_on;
    logic                lit;
    logic [7:0]          font_seg;
    logic [NDIG-1:0]     sel_nxt;
    logic [7:0]          seg_nxt;

    // run holds the counters at slot 0 / dwell 0 for one cycle after reset so
    // the first post-reset cycle is a proper frame start.
    always_ff @(posedge xClk or negedge xRst_n) begin
        if (!xRst_n) begin
            run   <= 1'b0;
            dwell <= '0;
            slot  <= '0;
        end else if (!run) begin
            run   <= 1'b1;
        end else if (dwell == DWELL_LAST) begin
            dwell <= '0;
            slot  <= (slot == SLOT_LAST) ? '0 : slot + 1'b1;
        end else begin
            dwell <= dwell + 1'b1;
        end
    end

    assign frame_start = run && (dwell == '0) && (slot == '0);
    assign xFrame      = frame_start;

    always_comb begin
        nxt_data  = shd_data;
        nxt_dp    = shd_dp;
        nxt_blank = shd_blank;
        nxt_lzs   = shd_lzs;
        if (frame_start) begin
            if (xLoad) begin
                nxt_data  = xDInput;
                nxt_dp    = xDp;
                nxt_blank = xBlank;
                nxt_lzs   = xLzs;
            end else if (pend) begin
                nxt_data  = pend_data;
                nxt_dp    = pend_dp;
                nxt_blank = pend_blank;
                nxt_lzs   = pend_lzs;
            end
        end
    end

    always_ff @(posedge xClk or negedge xRst_n) begin
        if (!xRst_n) begin
            shd_data  <= '0;
            shd_dp    <= '0;
            shd_blank <= '0;
            shd_lzs   <= 1'b0;
        end else begin
            shd_data  <= nxt_data;
            shd_dp    <= nxt_dp;
            shd_blank <= nxt_blank;
            shd_lzs   <= nxt_lzs;
        end
    end

    always_ff @(posedge xClk or negedge xRst_n) begin
        if (!xRst_n) begin
            pend       <= 1'b0;
            pend_data  <= '0;
            pend_dp    <= '0;
            pend_blank <= '0;
            pend_lzs   <= 1'b0;
        end else if (frame_start) begin
            pend       <= 1'b0;
        end else if (xLoad) begin
            pend       <= 1'b1;
            pend_data  <= xDInput;
            pend_dp    <= xDp;
            pend_blank <= xBlank;
            pend_lzs   <= xLzs;
        end
    end

    // Display decisions use nxt_* so the first slot of a frame already sees the
    // data being committed at that frame start.
    always_comb begin
        supp     = '0;
        zero_run = nxt_lzs;
        for (int d = NDIG - 1; d >= 1; d--) begin
            zero_run = zero_run && (nxt_data[4*d +: 4] == 4'h0) && !nxt_dp[d];
            supp[d]  = zero_run;
        end
    end

    assign dig_idx = SLOT_LAST - slot;

    always_comb begin
        cur_nib  = '0;
        cur_dp   = 1'b0;
        cur_dark = 1'b1;
        for (int d = 0; d < NDIG; d++) begin
            if (SW'(d) == dig_idx) begin
                cur_nib  = nxt_data[4*d +: 4];
                cur_dp   = nxt_dp[d];
                cur_dark = nxt_blank[d] || supp[d];
            end
        end
    end

    seg7_font u_font (
        .nibble   (cur_nib),
        .dp       (cur_dp),
        .segments (font_seg)
    );

    assign t_on = ((32'(xBright) + 32'd1) * 32'(DSTEP)) >> BRIGHT_W;
    assign lit  = run && (32'(dwell) < t_on) && !cur_dark;

    always_comb begin
        sel_nxt = '0;
        seg_nxt = '0;
        if (lit) begin
            sel_nxt = NDIG'(1) << dig_idx;
            seg_nxt = font_seg;
        end
    end

    always_ff @(posedge xClk or negedge xRst_n) begin
        if (!xRst_n) begin
            xSelect  <= SEL_OFF;
            xSegment <= SEG_OFF;
        end else begin
            xSelect  <= sel_nxt ^ SEL_OFF;
            xSegment <= seg_nxt ^ SEG_OFF;
        end
    end

endmodule
